cv32e40p_breakage_monitor_ft: RTL and testbench



---
 rtl/cv32e40p_pkg2_ft.sv | 35 +++
 rtl/cv32e40p_breakage_counter_ft.sv | 73 +++++++
 rtl/cv32e40p_breakage_monitor_ft.sv | 81 ++++++++
 tb/tb_cv32e40p_breakage_monitor_ft.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cv32e40p_pkg2_ft.sv
// Shared fault-tolerance definitions: breakage-monitor states and per-unit
// leaky-bucket tuning constants for the triplicated IF-stage units.
package cv32e40p_pkg2_ft;

   typedef enum logic [1:0] {
      BM_OK      = 2'd0,
      BM_SUSPECT = 2'd1,
      BM_BROKEN  = 2'd2
   } bm_state_e;

   localparam int NUM_REPLICAS = 3;

   localparam int PREFETCH_INCREMENT          = 1;
   localparam int PREFETCH_DECREMENT          = 1;
   localparam int PREFETCH_BREAKING_THRESHOLD = 3;
   localparam int PREFETCH_COUNT_BIT          = 8;
   localparam int PREFETCH_INC_DEC_BIT        = 2;

   localparam int ALIGNER_INCREMENT          = 2;
   localparam int ALIGNER_DECREMENT          = 1;
   localparam int ALIGNER_BREAKING_THRESHOLD = 8;
   localparam int ALIGNER_COUNT_BIT          = 8;
   localparam int ALIGNER_INC_DEC_BIT        = 2;

   localparam int COMPRESSED_DECODER_INCREMENT          = 1;
   localparam int COMPRESSED_DECODER_DECREMENT          = 1;
   localparam int COMPRESSED_DECODER_BREAKING_THRESHOLD = 4;
   localparam int COMPRESSED_DECODER_COUNT_BIT          = 8;
   localparam int COMPRESSED_DECODER_INC_DEC_BIT        = 2;

   function automatic logic [1:0] popcount3(input logic [2:0] v);
      return 2'(v[0]) + 2'(v[1]) + 2'(v[2]);
   endfunction

endpackage

// File: rtl/cv32e40p_breakage_counter_ft.sv
// One replica's saturating leaky-bucket error score and OK/SUSPECT/BROKEN FSM.
// BROKEN is absorbing until a synchronous clear.
module cv32e40p_breakage_counter_ft
   import cv32e40p_pkg2_ft::*;
#(
   parameter int INCREMENT          = 1,
   parameter int DECREMENT          = 1,
   parameter int BREAKING_THRESHOLD = 3,
   parameter int COUNT_BIT          = 8,
   parameter int INC_DEC_BIT        = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 sample_i,
   input  logic                 err_i,
   input  logic                 clear_i,
   output logic [COUNT_BIT-1:0] score_o,
   output logic                 broken_o,
   output logic                 enter_broken_o
);

   localparam logic [INC_DEC_BIT-1:0] INC_OP = INC_DEC_BIT'(INCREMENT);
   localparam logic [INC_DEC_BIT-1:0] DEC_OP = INC_DEC_BIT'(DECREMENT);
   localparam logic [COUNT_BIT:0]     INC_EXT = (COUNT_BIT+1)'(INC_OP);
   localparam logic [COUNT_BIT:0]     DEC_EXT = (COUNT_BIT+1)'(DEC_OP);
   localparam logic [COUNT_BIT-1:0]   THRESH  = COUNT_BIT'(BREAKING_THRESHOLD);

   bm_state_e              state_q, state_d;
   logic [COUNT_BIT-1:0]   score_q, score_d;
   logic [COUNT_BIT:0]     inc_sum;
   logic signed [COUNT_BIT:0] dec_diff;

   always_comb begin
      inc_sum  = {1'b0, score_q} + INC_EXT;
      dec_diff = $signed({1'b0, score_q}) - $signed(DEC_EXT);
      score_d  = score_q;
      state_d  = state_q;
      if (clear_i) begin
         score_d = '0;
         state_d = BM_OK;
      end else if (sample_i && (state_q != BM_BROKEN)) begin
         // The carry out of the widened sum marks overflow; a negative
         // difference means the bucket has drained below empty.
         if (err_i) begin
            score_d = inc_sum[COUNT_BIT] ? '1 : inc_sum[COUNT_BIT-1:0];
         end else begin
            score_d = dec_diff[COUNT_BIT] ? '0 : dec_diff[COUNT_BIT-1:0];
         end
         if (score_d >= THRESH) begin
            state_d = BM_BROKEN;
         end else if (score_d != '0) begin
            state_d = BM_SUSPECT;
         end else begin
            state_d = BM_OK;
         end
      end
      enter_broken_o = (state_d == BM_BROKEN) && (state_q != BM_BROKEN);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= BM_OK;
         score_q <= '0;
      end else begin
         state_q <= state_d;
         score_q <= score_d;
      end
   end

   assign score_o  = score_q;
   assign broken_o = (state_q == BM_BROKEN);

endmodule

// File: rtl/cv32e40p_breakage_monitor_ft.sv
// Breakage monitor for one TMR unit: three per-replica score counters plus
// registered event, uncorrectable and group-fail flags and the voter enables.
module cv32e40p_breakage_monitor_ft
   import cv32e40p_pkg2_ft::*;
#(
   parameter int INCREMENT          = 1,
   parameter int DECREMENT          = 1,
   parameter int BREAKING_THRESHOLD = 3,
   parameter int COUNT_BIT          = 8,
   parameter int INC_DEC_BIT        = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   err_valid_i,
   input  logic [2:0]             err_i,
   input  logic                   clear_i,
   output logic [2:0]             replica_en_o,
   output logic [2:0]             broken_o,
   output logic                   broken_event_o,
   output logic                   uncorrectable_o,
   output logic                   group_fail_o,
   output logic [3*COUNT_BIT-1:0] score_o
);

   logic [2:0] broken_w;
   logic [2:0] enter_w;
   logic [2:0] broken_next;
   logic       broken_event_q, broken_event_d;
   logic       uncorrectable_q, uncorrectable_d;
   logic       group_fail_q, group_fail_d;

   generate
      for (genvar gi = 0; gi < NUM_REPLICAS; gi++) begin : g_replica
         cv32e40p_breakage_counter_ft #(
            .INCREMENT          (INCREMENT),
            .DECREMENT          (DECREMENT),
            .BREAKING_THRESHOLD (BREAKING_THRESHOLD),
            .COUNT_BIT          (COUNT_BIT),
            .INC_DEC_BIT        (INC_DEC_BIT)
         ) u_counter (
            .clk            (clk),
            .rst            (rst),
            .sample_i       (err_valid_i),
            .err_i          (err_i[gi]),
            .clear_i        (clear_i),
            .score_o        (score_o[gi*COUNT_BIT +: COUNT_BIT]),
            .broken_o       (broken_w[gi]),
            .enter_broken_o (enter_w[gi])
         );
      end
   endgenerate

   always_comb begin
      broken_next     = clear_i ? 3'b000 : (broken_w | enter_w);
      broken_event_d  = |enter_w;
      uncorrectable_d = err_valid_i && (err_i == 3'b111);
      // Sticky: once two replicas are gone, majority voting is meaningless.
      group_fail_d    = !clear_i &&
                        (group_fail_q || (popcount3(broken_next) >= 2'd2));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         broken_event_q  <= 1'b0;
         uncorrectable_q <= 1'b0;
         group_fail_q    <= 1'b0;
      end else begin
         broken_event_q  <= broken_event_d;
         uncorrectable_q <= uncorrectable_d;
         group_fail_q    <= group_fail_d;
      end
   end

   // With a failed group, keep every replica enabled so the voter always has inputs.
   assign replica_en_o    = group_fail_q ? 3'b111 : ~broken_w;
   assign broken_o        = broken_w;
   assign broken_event_o  = broken_event_q;
   assign uncorrectable_o = uncorrectable_q;
   assign group_fail_o    = group_fail_q;

endmodule

// File: tb/tb_cv32e40p_breakage_monitor_ft.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// behavioural leaky-bucket model of the breakage monitor.
module tb_cv32e40p_breakage_monitor_ft;

   localparam int INC = 1;
   localparam int DEC = 1;
   localparam int THR = 3;
   localparam int CB  = 8;
   localparam int MAXS = (1 << CB) - 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          err_valid = 1'b0;
   logic [2:0]    err = 3'b000;
   logic          clear = 1'b0;
   logic [2:0]    replica_en;
   logic [2:0]    broken;
   logic          broken_event;
   logic          uncorrectable;
   logic          group_fail;
   logic [3*CB-1:0] score;

   logic          s_valid = 1'b0;
   logic [2:0]    s_err = 3'b000;
   logic          s_clear = 1'b0;
   logic [2:0]    s_en;
   logic [2:0]    s_broken;
   logic          s_evt;
   logic          s_unc;
   logic          s_gf;
   logic [5:0]    s_score;

   int checks = 0;
   int errors = 0;

   int       m_score [3];
   bit [2:0] m_broken;
   bit       m_gf, m_evt, m_unc;

   always #5 clk = ~clk;

   cv32e40p_breakage_monitor_ft dut (
      .clk(clk), .rst(rst), .err_valid_i(err_valid), .err_i(err), .clear_i(clear),
      .replica_en_o(replica_en), .broken_o(broken), .broken_event_o(broken_event),
      .uncorrectable_o(uncorrectable), .group_fail_o(group_fail), .score_o(score)
   );

   cv32e40p_breakage_monitor_ft #(
      .INCREMENT(3), .DECREMENT(1), .BREAKING_THRESHOLD(3), .COUNT_BIT(2), .INC_DEC_BIT(2)
   ) dut_sat (
      .clk(clk), .rst(rst), .err_valid_i(s_valid), .err_i(s_err), .clear_i(s_clear),
      .replica_en_o(s_en), .broken_o(s_broken), .broken_event_o(s_evt),
      .uncorrectable_o(s_unc), .group_fail_o(s_gf), .score_o(s_score)
   );

   task automatic model_reset();
      for (int k = 0; k < 3; k++) m_score[k] = 0;
      m_broken = 3'b000;
      m_gf = 0; m_evt = 0; m_unc = 0;
   endtask

   task automatic model_step(input bit v, input bit [2:0] e, input bit c);
      int s;
      m_unc = v && (e == 3'b111);
      m_evt = 0;
      if (c) begin
         for (int k = 0; k < 3; k++) m_score[k] = 0;
         m_broken = 3'b000;
         m_gf = 0;
      end else if (v) begin
         for (int k = 0; k < 3; k++) begin
            if (!m_broken[k]) begin
               if (e[k]) begin
                  s = m_score[k] + INC;
                  if (s > MAXS) s = MAXS;
               end else begin
                  s = m_score[k] - DEC;
                  if (s < 0) s = 0;
               end
               m_score[k] = s;
               if (s >= THR) begin
                  m_broken[k] = 1;
                  m_evt = 1;
               end
            end
         end
         if ($countones(m_broken) >= 2) m_gf = 1;
      end
   endtask

   function automatic logic [2:0] model_en();
      return m_gf ? 3'b111 : ~m_broken;
   endfunction

   function automatic int score_of(input int k);
      return int'(score[k*CB +: CB]);
   endfunction

   // Drive one cycle, take the edge, advance the model; outputs sampled 1 ns later.
   task automatic cycle(input bit v, input bit [2:0] e, input bit c);
      err_valid = v; err = e; clear = c;
      @(posedge clk);
      #1;
      model_step(v, e, c);
      err_valid = 0; err = 3'b000; clear = 0;
      $display("cycle v=%0b err=%03b clr=%0b -> score=%0d/%0d/%0d broken=%03b evt=%0b unc=%0b gf=%0b en=%03b",
               v, e, c, score_of(0), score_of(1), score_of(2), broken, broken_event,
               uncorrectable, group_fail, replica_en);
   endtask

   task automatic test_reset();
      rst = 1;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (score !== '0) begin errors++; $display("FAIL reset_score got=%h want=0", score); end
      checks++; if (broken !== 3'b000) begin errors++; $display("FAIL reset_broken got=%03b want=000", broken); end
      checks++; if (replica_en !== 3'b111) begin errors++; $display("FAIL reset_en got=%03b want=111", replica_en); end
      checks++; if ({broken_event, uncorrectable, group_fail} !== 3'b000) begin
         errors++; $display("FAIL reset_flags got=%03b want=000", {broken_event, uncorrectable, group_fail}); end
      @(negedge clk);
      rst = 0;
      model_reset();
   endtask

   task automatic test_break_single();
      cycle(0, 3'b000, 1);
      for (int i = 0; i < 3; i++) begin
         cycle(1, 3'b001, 0);
         checks++; if (score_of(0) !== i + 1) begin errors++; $display("FAIL single_score i=%0d got=%0d want=%0d", i, score_of(0), i + 1); end
         checks++; if (broken_event !== (i == 2)) begin errors++; $display("FAIL single_event i=%0d got=%0b want=%0b", i, broken_event, i == 2); end
      end
      checks++; if (broken !== 3'b001) begin errors++; $display("FAIL single_broken got=%03b want=001", broken); end
      checks++; if (replica_en !== 3'b110) begin errors++; $display("FAIL single_en got=%03b want=110", replica_en); end
      cycle(1, 3'b001, 0);
      checks++; if (broken_event !== 1'b0) begin errors++; $display("FAIL single_pulse_len got=%0b want=0", broken_event); end
      checks++; if (score_of(0) !== 3) begin errors++; $display("FAIL single_frozen got=%0d want=3", score_of(0)); end
   endtask

   task automatic test_leak();
      int exp_s [4] = '{1, 2, 1, 0};
      logic [2:0] pat [4] = '{3'b010, 3'b010, 3'b000, 3'b000};
      cycle(0, 3'b000, 1);
      for (int i = 0; i < 4; i++) begin
         cycle(1, pat[i], 0);
         checks++; if (score_of(1) !== exp_s[i]) begin errors++; $display("FAIL leak_score i=%0d got=%0d want=%0d", i, score_of(1), exp_s[i]); end
         checks++; if (broken_event !== 1'b0) begin errors++; $display("FAIL leak_event i=%0d got=%0b want=0", i, broken_event); end
      end
      checks++; if (broken !== 3'b000) begin errors++; $display("FAIL leak_broken got=%03b want=000", broken); end
   endtask

   task automatic test_valid_low();
      cycle(0, 3'b000, 1);
      cycle(1, 3'b101, 0);
      for (int i = 0; i < 2; i++) begin
         cycle(0, 3'b111, 0);
         checks++; if ({score_of(0), score_of(1), score_of(2)} !== {32'd1, 32'd0, 32'd1}) begin
            errors++; $display("FAIL hold_scores got=%0d/%0d/%0d want=1/0/1", score_of(0), score_of(1), score_of(2)); end
         checks++; if (uncorrectable !== 1'b0) begin errors++; $display("FAIL hold_unc got=%0b want=0", uncorrectable); end
      end
   endtask

   task automatic test_saturate();
      s_valid = 1; s_err = 3'b001;
      @(posedge clk); #1;
      checks++; if (s_score[1:0] !== 2'd3) begin errors++; $display("FAIL sat_score got=%0d want=3", s_score[1:0]); end
      checks++; if (s_broken !== 3'b001) begin errors++; $display("FAIL sat_broken got=%03b want=001", s_broken); end
      checks++; if (s_evt !== 1'b1) begin errors++; $display("FAIL sat_event got=%0b want=1", s_evt); end
      repeat (2) @(posedge clk);
      #1;
      s_valid = 0; s_err = 3'b000;
      checks++; if (s_score !== 6'b00_00_11) begin errors++; $display("FAIL sat_frozen got=%h want=03", s_score); end
      checks++; if (s_evt !== 1'b0) begin errors++; $display("FAIL sat_pulse_len got=%0b want=0", s_evt); end
      $display("saturate score=%h broken=%03b", s_score, s_broken);
   endtask

   task automatic test_group_fail();
      int evts = 0;
      cycle(0, 3'b000, 1);
      repeat (3) cycle(1, 3'b001, 0);
      for (int i = 0; i < 3; i++) begin
         cycle(1, 3'b110, 0);
         evts += int'(broken_event);
         checks++; if (group_fail !== (i == 2)) begin errors++; $display("FAIL gf_assert i=%0d got=%0b want=%0b", i, group_fail, i == 2); end
      end
      checks++; if (evts !== 1 || broken_event !== 1'b1) begin errors++; $display("FAIL gf_events got=%0d want=1", evts); end
      checks++; if (broken !== 3'b111) begin errors++; $display("FAIL gf_broken got=%03b want=111", broken); end
      checks++; if (replica_en !== 3'b111) begin errors++; $display("FAIL gf_en got=%03b want=111", replica_en); end
      cycle(0, 3'b000, 0);
      checks++; if (group_fail !== 1'b1 || broken_event !== 1'b0) begin
         errors++; $display("FAIL gf_sticky got=gf%0b/evt%0b want=gf1/evt0", group_fail, broken_event); end
   endtask

   task automatic test_uncorrectable();
      cycle(0, 3'b000, 1);
      checks++; if (group_fail !== 1'b0) begin errors++; $display("FAIL clear_gf got=%0b want=0", group_fail); end
      cycle(1, 3'b111, 0);
      checks++; if (uncorrectable !== 1'b1) begin errors++; $display("FAIL unc_pulse got=%0b want=1", uncorrectable); end
      checks++; if ({score_of(0), score_of(1), score_of(2)} !== {32'd1, 32'd1, 32'd1}) begin
         errors++; $display("FAIL unc_scores got=%0d/%0d/%0d want=1/1/1", score_of(0), score_of(1), score_of(2)); end
      cycle(1, 3'b001, 1);
      checks++; if (score !== '0) begin errors++; $display("FAIL clear_prio got=%h want=0", score); end
      checks++; if (uncorrectable !== 1'b0) begin errors++; $display("FAIL unc_len got=%0b want=0", uncorrectable); end
   endtask

   task automatic test_random();
      bit v, c;
      bit [2:0] e;
      cycle(0, 3'b000, 1);
      for (int n = 0; n < 400; n++) begin
         v = ($urandom_range(3) != 0);
         for (int k = 0; k < 3; k++) e[k] = ($urandom_range(3) == 0);
         c = ($urandom_range(29) == 0);
         cycle(v, e, c);
         for (int k = 0; k < 3; k++) begin
            checks++; if (score_of(k) !== m_score[k]) begin errors++; $display("FAIL rnd_score n=%0d k=%0d got=%0d want=%0d", n, k, score_of(k), m_score[k]); end
         end
         checks++; if (broken !== m_broken) begin errors++; $display("FAIL rnd_broken n=%0d got=%03b want=%03b", n, broken, m_broken); end
         checks++; if (broken_event !== m_evt) begin errors++; $display("FAIL rnd_event n=%0d got=%0b want=%0b", n, broken_event, m_evt); end
         checks++; if (uncorrectable !== m_unc) begin errors++; $display("FAIL rnd_unc n=%0d got=%0b want=%0b", n, uncorrectable, m_unc); end
         checks++; if (group_fail !== m_gf) begin errors++; $display("FAIL rnd_gf n=%0d got=%0b want=%0b", n, group_fail, m_gf); end
         checks++; if (replica_en !== model_en()) begin errors++; $display("FAIL rnd_en n=%0d got=%03b want=%03b", n, replica_en, model_en()); end
      end
   endtask

   task automatic test_async_reset();
      cycle(0, 3'b000, 1);
      repeat (2) cycle(1, 3'b100, 0);
      checks++; if (score_of(2) !== 2) begin errors++; $display("FAIL areset_pre got=%0d want=2", score_of(2)); end
      #3;
      rst = 1;
      #1;
      checks++; if (score !== '0) begin errors++; $display("FAIL areset_score got=%h want=0", score); end
      checks++; if ({broken, replica_en} !== 6'b000_111) begin errors++; $display("FAIL areset_state got=%03b/%03b want=000/111", broken, replica_en); end
      checks++; if ({broken_event, uncorrectable, group_fail} !== 3'b000) begin
         errors++; $display("FAIL areset_flags got=%03b want=000", {broken_event, uncorrectable, group_fail}); end
      $display("async reset applied mid-cycle score=%h", score);
      @(negedge clk);
      rst = 0;
      model_reset();
   endtask

   initial begin
      test_reset();
      test_break_single();
      test_leak();
      test_valid_low();
      test_saturate();
      test_group_fail();
      test_uncorrectable();
      test_random();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
